// File: rtl/adder_sum_accumulator.sv
// Burst accumulator behind the ripple-carry adder: sums LEN unsigned words
// into a wider register and holds the total plus a sticky overflow flag until accepted.
module adder_sum_accumulator #(
  parameter int N     = 4,
  parameter int ACC_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [N:0]       in_sum,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  logic             xfer;
  logic [ACC_W:0]   sum_w;

  // in_ready depends on state alone, so it never combinationally follows in_valid.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;

  assign xfer  = in_valid & in_ready;
  // The extra top bit catches the carry out of the accumulator width.
  assign sum_w = {1'b0, acc_q} + {{(ACC_W-N){1'b0}}, in_sum};

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          rem_d   = len;
          state_d = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (xfer) begin
          acc_d = sum_w[ACC_W-1:0];
          ovf_d = ovf_q | sum_w[ACC_W];
          rem_d = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Directed bench for adder_sum_accumulator: hand-computed bursts covering
// wrap/overflow, zero length, output back-pressure, input bubbles and mid-burst reset.
module tb_adder_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic [4:0] in_sum;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_acc;
  logic       out_ovf;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  adder_sum_accumulator #(.N(4), .ACC_W(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_sum    (in_sum),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_burst(input logic [3:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [4:0] v);
    in_valid = 1'b1;
    in_sum   = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_sum    = '0;
    out_ready = 1'b0;
    #22;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 0);
    check("rst_acc", out_acc, 0);
    check("rst_ovf", out_ovf, 0);
    rst_n = 1'b1;
    tick();
    check("idle_after_release", busy, 0);

    // 1: 5 + 10 + 31 = 46
    begin_burst(4'd3);
    check("t1_ready", in_ready, 1);
    send_word(5'd5);
    send_word(5'd10);
    check("t1_not_yet", out_valid, 0);
    send_word(5'd31);
    check("t1_valid", out_valid, 1);
    check("t1_acc", out_acc, 8'h2E);
    check("t1_ovf", out_ovf, 0);
    check("t1_ready_done", in_ready, 0);
    accept();
    check("t1_idle_valid", out_valid, 0);
    check("t1_idle_busy", busy, 0);

    // 2: 10 * 31 = 310 -> 54 with overflow
    begin_burst(4'd10);
    for (int i = 0; i < 10; i++) send_word(5'd31);
    check("t2_valid", out_valid, 1);
    check("t2_acc", out_acc, 8'h36);
    check("t2_ovf", out_ovf, 1);
    accept();

    // in_valid while idle must not be consumed
    in_valid = 1'b1;
    in_sum   = 5'd9;
    check("idle_in_ready", in_ready, 0);
    tick();
    in_valid = 1'b0;
    check("idle_word_ignored", busy, 0);

    // 3: zero-length burst
    begin_burst(4'd0);
    check("t3_in_ready", in_ready, 0);
    check("t3_valid", out_valid, 1);
    check("t3_acc", out_acc, 0);
    check("t3_ovf", out_ovf, 0);
    accept();
    check("t3_idle", busy, 0);

    // 4: back-pressure with start pulsed while DONE
    begin_burst(4'd2);
    send_word(5'd7);
    send_word(5'd9);
    start = 1'b1;
    len   = 4'd5;
    for (int i = 0; i < 5; i++) begin
      check("t4_held_valid", out_valid, 1);
      check("t4_held_acc", out_acc, 8'd16);
      check("t4_held_ovf", out_ovf, 0);
      tick();
    end
    start = 1'b0;
    check("t4_still_valid", out_valid, 1);
    accept();
    check("t4_idle_busy", busy, 0);
    check("t4_idle_valid", out_valid, 0);

    // 5: bubbles 1,0,1,0,1,1 -> four words of 3
    begin_burst(4'd4);
    send_word(5'd3);
    tick();
    check("t5_gap_ready", in_ready, 1);
    send_word(5'd3);
    tick();
    send_word(5'd3);
    check("t5_not_yet", out_valid, 0);
    send_word(5'd3);
    check("t5_valid", out_valid, 1);
    check("t5_acc", out_acc, 8'd12);
    in_valid = 1'b1;
    in_sum   = 5'd3;
    tick();
    in_valid = 1'b0;
    check("t5_done_ignores_in", out_acc, 8'd12);
    accept();

    // 6: reset mid-burst, then a fresh len=1 burst
    begin_burst(4'd5);
    send_word(5'd4);
    send_word(5'd6);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_ready", in_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();
    begin_burst(4'd1);
    send_word(5'd1);
    check("t6_valid", out_valid, 1);
    check("t6_acc", out_acc, 8'd1);
    check("t6_ovf", out_ovf, 0);
    accept();
    check("t6_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
